// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and default bit timing.
// Defaults target 50 MHz / 9600 baud; SIM builds use short periods.
package uart_pkg;

    localparam int UART_DW = 8;
    localparam int CNT_W   = 13;

`ifdef SIM
    localparam logic [CNT_W-1:0] T_DIV_DEF      = 13'd7;
    localparam logic [CNT_W-1:0] T_DIV_HALF_DEF = 13'd3;
`else
    localparam logic [CNT_W-1:0] T_DIV_DEF      = 13'd5208;
    localparam logic [CNT_W-1:0] T_DIV_HALF_DEF = 13'd2604;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rxd line plus falling-edge detect.
// All flops reset high so a released reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic n_rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rxd_s = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its midpoint, strobes rx_done on a good
// stop bit and frame_err on a low one.
//   state   | meaning
//   S_IDLE  | line idle, waiting for a falling edge
//   S_START | timing to the start-bit midpoint, rejecting glitches
//   S_DATA  | sampling 8 data bits LSB first
//   S_STOP  | sampling the stop bit, then publishing the result
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [CNT_W-1:0] T_DIV      = T_DIV_DEF,
    parameter logic [CNT_W-1:0] T_DIV_HALF = T_DIV_HALF_DEF
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               rxd,
    output logic [UART_DW-1:0] rx_data,
    output logic               rx_done,
    output logic               frame_err,
    output logic               busy
);

    localparam logic [CNT_W-1:0] DIV_LAST  = T_DIV - 13'd1;
    localparam logic [CNT_W-1:0] HALF_LAST = T_DIV_HALF - 13'd1;

    logic rxd_s;
    logic fall;

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [UART_DW-1:0] shift_q, shift_d;
    logic [UART_DW-1:0] data_q, data_d;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .rxd   (rxd),
        .rxd_s (rxd_s),
        .fall  (fall)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rxd_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            S_STOP: begin
                // Leaving at the stop midpoint lets a back-to-back start edge be caught.
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rxd_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames are driven onto rxd and the received
// events are compared against a frame-level model of what the line carried.
module tb_uart_rx;

    localparam int TD = 7;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int overlap = 0;
    bit busy_seen = 1'b0;

    // Event encoding: {is_error, byte}; errors carry byte 0.
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx #(.T_DIV(13'd7), .T_DIV_HALF(13'd3)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (n_rst) begin
            if (rx_done && frame_err) overlap++;
            if (rx_done) got_q.push_back({1'b0, rx_data});
            else if (frame_err) got_q.push_back(9'h100);
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    // mode 0: nominal period; 1/2: each bit alternately one clock long/short.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int mode);
        logic [9:0] bits;
        int p;
        bits = {stop_v, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            p = TD;
            if (mode == 1) p = (j % 2 == 0) ? TD + 1 : TD - 1;
            if (mode == 2) p = (j % 2 == 0) ? TD - 1 : TD + 1;
            drive_bit(bits[j], p);
        end
        if (stop_v) begin
            exp_q.push_back({1'b0, b});
            last_good = b;
        end else begin
            exp_q.push_back(9'h100);
        end
    endtask

    task automatic check_events(input string tag);
        int n;
        check_val({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val({tag, "_event"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        logic       err;
        int         gap;

        #25;
        check_val("rst_rx_data", 32'(rx_data), 32'h00);
        check_val("rst_rx_done", 32'(rx_done), 32'h0);
        check_val("rst_frame_err", 32'(frame_err), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #2 n_rst = 1'b1;
        drive_bit(1'b1, 2 * TD);

        // single byte
        send_frame(8'h37, 1'b1, 0);
        drive_bit(1'b1, 2 * TD);
        check_events("t1");
        check_val("t1_rx_data", 32'(rx_data), 32'h37);
        check_val("t1_busy", 32'(busy), 32'h0);

        // back-to-back, no idle gap
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        drive_bit(1'b1, 2 * TD);
        check_events("t2");

        // glitch shorter than half a bit
        busy_seen = 1'b0;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 3 * TD);
        check_val("t3_busy_seen", 32'(busy_seen), 32'h1);
        check_val("t3_busy_idle", 32'(busy), 32'h0);
        check_events("t3");
        check_val("t3_rx_data", 32'(rx_data), 32'hFF);

        // framing error followed by a long break
        send_frame(8'h37, 1'b1, 0);
        send_frame(8'h55, 1'b0, 0);
        drive_bit(1'b0, 30 * TD);
        check_events("t4");
        check_val("t4_rx_data", 32'(rx_data), 32'h37);
        drive_bit(1'b1, 2 * TD);
        check_events("t4_rise");

        // reset in the middle of data bit 4 of 0xA5
        b = 8'hA5;
        drive_bit(1'b0, TD);
        for (int i = 0; i < 4; i++) drive_bit(b[i], TD);
        rxd = b[4];
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        check_val("t5_rx_data", 32'(rx_data), 32'h00);
        check_val("t5_busy", 32'(busy), 32'h0);
        last_good = 8'h00;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b1;
        drive_bit(1'b1, 2 * TD);
        check_events("t5_none");
        send_frame(8'h20, 1'b1, 0);
        drive_bit(1'b1, 2 * TD);
        check_events("t5");
        check_val("t5_rx_data2", 32'(rx_data), 32'h20);

        // bit periods jittered by one clock either way
        send_frame(8'hC3, 1'b1, 1);
        drive_bit(1'b1, 2 * TD);
        send_frame(8'hC3, 1'b1, 2);
        drive_bit(1'b1, 2 * TD);
        check_events("t6");
        check_val("t6_rx_data", 32'(rx_data), 32'hC3);

        // randomised stream: bytes, gaps, phases and occasional bad stop bits
        for (int k = 0; k < 40; k++) begin
            b   = 8'($urandom_range(0, 255));
            err = ($urandom_range(0, 7) == 0);
            gap = err ? $urandom_range(1, 2) : $urandom_range(0, 2);
            send_frame(b, ~err, 0);
            drive_bit(1'b1, gap * TD + ((gap > 0) ? $urandom_range(0, 3) : 0));
        end
        drive_bit(1'b1, 2 * TD);
        check_events("rand");
        check_val("rand_rx_data", 32'(rx_data), 32'(last_good));
        check_val("rand_busy", 32'(busy), 32'h0);
        check_val("done_err_overlap", 32'(overlap), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver paired with the existing uart_tx. It deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous rxd line into bytes. Bit timing uses the same T_DIV clock-divider convention as uart_tx, so a uart_tx/uart_rx loopback with matching parameters is lossless. It sits at the board-side serial input and feeds the byte-level logic through a one-cycle rx_done strobe.

Parameters:
T_DIV, 13'd5208, clocks per bit period (50 MHz / 9600 baud); the simulation bench uses 13'd7
T_DIV_HALF, 13'd2604, clocks from the start-bit falling edge to the start-bit midpoint; the simulation bench uses 13'd3

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
rxd  input  1  serial line, idle high, asynchronous to clk
rx_data  output  8  last correctly framed byte; holds its value until the next good frame
rx_done  output  1  one-cycle pulse when rx_data has just been updated
frame_err  output  1  one-cycle pulse when the stop bit is sampled low
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on n_rst, applied to every flop.
- Reset values: rx_data=8'h00, rx_done=0, frame_err=0, busy=0, FSM=IDLE, counters=0. Synchroniser flops reset to 1 (line idle).
- Input path: rxd passes through a 2-FF synchroniser (rxd_s). A third flop supplies the previous value, and fall = prev & ~rxd_s.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: the baud counter is held at 0. On fall, go to START.
- START: count to T_DIV_HALF-1, then sample rxd_s.
  - rxd_s=0: valid start bit. Clear the counter, set bit_idx=0, go to DATA.
  - rxd_s=1: glitch. Return to IDLE with no output pulse.
- DATA: count 0..T_DIV-1. At T_DIV-1, sample rxd_s into shift[bit_idx] (LSB first) and increment bit_idx (3-bit). After bit_idx=7 is sampled, go to STOP.
- STOP: count 0..T_DIV-1, then sample at T_DIV-1.
  - Sample=1: rx_data<=shift and rx_done=1 on the next cycle.
  - Sample=0: frame_err=1 on the next cycle; rx_data is unchanged.
  - Either way, return to IDLE.
- Latency: the rx_done/frame_err pulse appears one clk after the stop-bit midpoint sample. That is about 9.5 bit times plus 3 clk (synchroniser and edge flop) after the line's start edge.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge one half bit later is caught. No idle gap between frames is required.
- Framing-error recovery: after a low stop bit, IDLE arms only on a real 1→0 transition. A line held low (break) produces exactly one frame_err, then nothing until rxd rises and falls again.
- Reset mid-frame: all state returns to reset values immediately; no partial byte or pulse is emitted. The first falling edge after release starts a clean frame.
- Counter width: 13 bits. Compare with == only; no wrap occurs because the counter is cleared on every state change.
- rx_done and frame_err are never high in the same cycle.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding (2-bit localparams S_IDLE, S_START, S_DATA, S_STOP);
  - UART_DW=8;
  - default T_DIV/T_DIV_HALF for 50 MHz/9600;
  - simulation values 7/3 under `ifdef SIM.
- uart_tx may adopt the same package later.
- One natural sub-module: uart_rx_sync. It contains the 2-FF synchroniser plus the falling-edge detector, with reset-high flops. Its ports are clk, n_rst, rxd, rxd_s, fall.

Test Plan:
1. Loopback with uart_tx (T_DIV=7, T_DIV_HALF=3, T_CLK=20 ns). Send 8'h37 -> rx_data=8'h37, exactly one rx_done pulse, frame_err stays 0, busy returns to 0.
2. Back-to-back bytes 8'h00 then 8'hFF with no idle gap -> two rx_done pulses, with rx_data 8'h00 then 8'hFF.
3. Glitch: drive rxd low for 2 clk, then high -> busy pulses briefly, then returns to IDLE. No rx_done or frame_err; rx_data is unchanged.
4. Framing error: drive frame 8'h55 with the stop bit low -> one frame_err pulse, no rx_done, rx_data keeps its prior 8'h37. Hold rxd low 30 bit times -> no further pulses.
5. Reset mid-frame: assert n_rst during data bit 4 of 8'hA5 -> rx_data=0 and busy=0 immediately. After release, send 8'h20 -> rx_data=8'h20, one rx_done pulse.
6. Baud tolerance: drive the bit period at T_DIV±1 clk with byte 8'hC3 -> rx_data=8'hC3, frame_err stays 0.
